// File: rtl/aes_192_sed_pkg.sv
// Shared constants, types and GF(2^8) helpers for the AES-192 counter-mode core.
package aes_192_sed_pkg;

  localparam int NR = 12;
  localparam int NK = 6;

  // Element [0] is the most-significant word, i.e. column 0 / FIPS-197 bytes 0..3.
  typedef logic [0:3][31:0] block_t;

  typedef enum logic {ST_IDLE, ST_BUSY} fsm_e;

  typedef struct packed {
    logic       sub_en;  // one of this round's four new key words needs RotWord/SubWord
    logic       sub_hi;  // that word is the third new word rather than the first
    logic [7:0] rcon;
  } ks_ctrl_t;

  localparam logic [7:0] RCON [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                      8'h10, 8'h20, 8'h40, 8'h80};

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at bit offset (255 - x) * 8 because entry 0 is the leftmost byte.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] base;
    base = {~x, 3'b000};
    return SBOX_TABLE[base +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Round r generates key words 4r+2..4r+5; at most one index in that span is a multiple of 6.
  function automatic ks_ctrl_t ks_ctrl(input logic [3:0] round);
    ks_ctrl_t c;
    c = '0;
    case (round)
      4'd1:    c = '{sub_en: 1'b1, sub_hi: 1'b0, rcon: RCON[0]};
      4'd2:    c = '{sub_en: 1'b1, sub_hi: 1'b1, rcon: RCON[1]};
      4'd4:    c = '{sub_en: 1'b1, sub_hi: 1'b0, rcon: RCON[2]};
      4'd5:    c = '{sub_en: 1'b1, sub_hi: 1'b1, rcon: RCON[3]};
      4'd7:    c = '{sub_en: 1'b1, sub_hi: 1'b0, rcon: RCON[4]};
      4'd8:    c = '{sub_en: 1'b1, sub_hi: 1'b1, rcon: RCON[5]};
      4'd10:   c = '{sub_en: 1'b1, sub_hi: 1'b0, rcon: RCON[6]};
      4'd11:   c = '{sub_en: 1'b1, sub_hi: 1'b1, rcon: RCON[7]};
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/aes_192_sed_sbox.sv
// Combinational AES forward S-box, one byte.
module aes_sbox
  import aes_192_sed_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  assign out_o = sbox(in_i);

endmodule

// File: rtl/aes_192_sed.sv
// AES-192 counter-mode encrypt/decrypt core: one cipher round per cycle, round keys
// expanded on the fly from a sliding six-word window, result XORed with p_c_text.
module aes_192_sed
  import aes_192_sed_pkg::*;
(
  input  logic         clk,
  input  logic         rst_ni,
  input  logic [127:0] state,
  input  logic [127:0] p_c_text,
  input  logic [191:0] key,
  input  logic         start,
  output logic [127:0] out,
  output logic         out_valid
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  logic         start_q;
  logic [127:0] out_q, out_d;
  logic         out_valid_q, out_valid_d;
  logic         launch, load, step;

  logic [127:0] data_q, ptext_q;
  logic [31:0]  kw_q [NK];   // key words w[4r-4] .. w[4r+1] while in round r
  logic [31:0]  kw_n [4];    // key words w[4r+2] .. w[4r+5]

  logic [7:0]   sb_out [16];
  block_t       sr_blk, mc_blk, rk_blk;
  logic [127:0] round_out;

  ks_ctrl_t     ks;
  logic [31:0]  sub_src, rot, sub_word, sub_rcon;

  assign launch = start & ~start_q;

  // ---------------- round datapath ----------------
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (.in_i(data_q[127-8*i -: 8]), .out_o(sb_out[i]));
  end

  always_comb begin
    sr_blk = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_blk[c][31-8*r -: 8] = sb_out[4*((c + r) % 4) + r];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 4; c++) mc_blk[c] = mix_column(sr_blk[c]);
  end

  assign rk_blk    = {kw_q[4], kw_q[5], kw_n[0], kw_n[1]};
  assign round_out = ((round_q == LAST_ROUND) ? sr_blk : mc_blk) ^ rk_blk;

  // ---------------- key schedule ----------------
  // When the substituted word is the third new one, its predecessor is w0^w1^w5 of the window;
  // sourcing it that way keeps the SubWord input independent of the SubWord output.
  assign ks      = ks_ctrl(round_q);
  assign sub_src = ks.sub_hi ? (kw_q[0] ^ kw_q[1] ^ kw_q[5]) : kw_q[5];
  assign rot     = {sub_src[23:0], sub_src[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_ks_sbox
    aes_sbox u_ks_sbox (.in_i(rot[31-8*j -: 8]), .out_o(sub_word[31-8*j -: 8]));
  end

  assign sub_rcon = sub_word ^ {ks.rcon, 24'h0};

  always_comb begin
    kw_n[0] = kw_q[0] ^ ((ks.sub_en && !ks.sub_hi) ? sub_rcon : kw_q[5]);
    kw_n[1] = kw_q[1] ^ kw_n[0];
    kw_n[2] = kw_q[2] ^ ((ks.sub_en &&  ks.sub_hi) ? sub_rcon : kw_n[1]);
    kw_n[3] = kw_q[3] ^ kw_n[2];
  end

  // ---------------- control FSM ----------------
  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    fsm_d       = fsm_q;
    round_d     = round_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    load        = 1'b0;
    step        = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (launch) begin
          fsm_d       = ST_BUSY;
          round_d     = 4'd1;
          out_valid_d = 1'b0;
          load        = 1'b1;
        end
      end
      ST_BUSY: begin
        step    = 1'b1;
        round_d = round_q + 4'd1;
        if (round_q == LAST_ROUND) begin
          fsm_d       = ST_IDLE;
          round_d     = 4'd0;
          out_d       = round_out ^ ptext_q;
          out_valid_d = 1'b1;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q       <= ST_IDLE;
      round_q     <= 4'd0;
      start_q     <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      round_q     <= round_d;
      start_q     <= start;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // NOTE: working registers are left unreset; they are always loaded at launch before being read.
  always_ff @(posedge clk) begin
    if (load) begin
      data_q  <= state ^ key[191:64];
      ptext_q <= p_c_text;
      for (int i = 0; i < NK; i++) kw_q[i] <= key[191-32*i -: 32];
    end else if (step) begin
      data_q <= round_out;
      kw_q[0] <= kw_q[4];
      kw_q[1] <= kw_q[5];
      for (int i = 0; i < 4; i++) kw_q[i+2] <= kw_n[i];
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_aes_192_sed.sv
// Self-checking bench for aes_192_sed against a byte-level AES-192 reference model.
module tb_aes_192_sed;

  localparam logic [191:0] KAT_KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] KAT_ST  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] KAT_INV = 128'h2256835b79b3201f91508f5f13f28e6e;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic [127:0] state, p_c_text;
  logic [191:0] key;
  logic         start;
  logic [127:0] out;
  logic         out_valid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] msb [256];

  aes_192_sed dut (
    .clk      (clk),
    .rst_ni   (rst_ni),
    .state    (state),
    .p_c_text (p_c_text),
    .key      (key),
    .start    (start),
    .out      (out),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic init_model();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (m_mul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      msb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] m_aes192(input logic [191:0] k, input logic [127:0] blk);
    logic [31:0]  w [52];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 6; i++) w[i] = k[191-32*i -: 32];
    for (int i = 6; i < 52; i++) begin
      tmp = w[i-1];
      if (i % 6 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {msb[tmp[31:24]], msb[tmp[23:16]], msb[tmp[15:8]], msb[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = m_mul(rc, 8'h02);
      end
      w[i] = w[i-6] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 12; r++) begin
      for (int i = 0; i < 16; i++) s[i] = msb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[4*c+row] = s[4*((c+row)%4)+row];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 12) begin
          s[4*c]   = m_mul(a0, 8'h02) ^ m_mul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ m_mul(a1, 8'h02) ^ m_mul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ m_mul(a2, 8'h02) ^ m_mul(a3, 8'h03);
          s[4*c+3] = m_mul(a0, 8'h03) ^ a1 ^ a2 ^ m_mul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] ^= w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [191:0] rnd192();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of edges after the launch edge until out_valid reads 1.
  task automatic run_op(input logic [191:0] k, input logic [127:0] st, input logic [127:0] pt,
                        output int lat);
    key = k; state = st; p_c_text = pt;
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_ni = 1'b0; start = 1'b0; key = '0; state = '0; p_c_text = '0;
    #3;
    n_tests++;
    if (out !== 128'h0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in: out=%h valid=%b want 0/0", out, out_valid);
    end
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_tests++;
    if (out !== 128'h0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: out=%h valid=%b want 0/0", out, out_valid);
    end
  endtask

  task automatic test_kat();
    key = KAT_KEY; state = KAT_ST; p_c_text = '0;
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    for (int k = 1; k <= 11; k++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL kat_busy cycle %0d: valid=%b want 0", k, out_valid);
      end
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out !== KAT_CT) begin
      n_fail++;
      $display("FAIL kat_result: valid=%b out=%h want 1 %h", out_valid, out, KAT_CT);
    end
  endtask

  task automatic test_xor_modes();
    int lat;
    run_op(KAT_KEY, KAT_ST, KAT_CT, lat);
    n_tests++;
    if (lat != 12 || out !== 128'h0) begin
      n_fail++;
      $display("FAIL decrypt: lat=%0d out=%h want 12 0", lat, out);
    end
    run_op(KAT_KEY, KAT_ST, {128{1'b1}}, lat);
    n_tests++;
    if (lat != 12 || out !== KAT_INV) begin
      n_fail++;
      $display("FAIL keystream: lat=%0d out=%h want 12 %h", lat, out, KAT_INV);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [191:0] k;
    logic [127:0] st, pt, exp;
    for (int n = 0; n < 6; n++) begin
      k = rnd192(); st = rnd128(); pt = rnd128();
      exp = m_aes192(k, st) ^ pt;
      run_op(k, st, pt, lat);
      n_tests++;
      if (lat != 12 || out !== exp) begin
        n_fail++;
        $display("FAIL random %0d: lat=%0d out=%h want 12 %h", n, lat, out, exp);
      end
    end
  endtask

  task automatic test_isolation();
    int good;
    key = KAT_KEY; state = KAT_ST; p_c_text = '0;
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    for (int k = 1; k <= 12; k++) begin
      if (k <= 11) begin
        key = rnd192(); state = rnd128(); p_c_text = rnd128();
      end
      if (k == 3) start = 1'b0;
      if (k == 6) start = 1'b1;
      tick();
    end
    n_tests++;
    if (out_valid !== 1'b1 || out !== KAT_CT) begin
      n_fail++;
      $display("FAIL isolation: valid=%b out=%h want 1 %h", out_valid, out, KAT_CT);
    end
    good = 0;
    for (int k = 0; k < 15; k++) begin
      key = rnd192(); state = rnd128(); p_c_text = rnd128();
      tick();
      if (out_valid === 1'b1 && out === KAT_CT) good++;
    end
    n_tests++;
    if (good != 15) begin
      n_fail++;
      $display("FAIL start_held: stable cycles=%0d want 15", good);
    end
  endtask

  task automatic test_relaunch();
    int lat;
    logic [191:0] k;
    logic [127:0] st, pt, exp;
    k = rnd192(); st = rnd128(); pt = rnd128();
    exp = m_aes192(k, st) ^ pt;
    key = k; state = st; p_c_text = pt;
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL relaunch_clear: valid=%b want 0", out_valid);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    n_tests++;
    if (lat != 12 || out !== exp) begin
      n_fail++;
      $display("FAIL relaunch_result: lat=%0d out=%h want 12 %h", lat, out, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [191:0] k1, k2;
    logic [127:0] s1, s2, p1, p2, e1, e2;
    k1 = rnd192(); s1 = rnd128(); p1 = rnd128();
    k2 = rnd192(); s2 = rnd128(); p2 = rnd128();
    e1 = m_aes192(k1, s1) ^ p1;
    e2 = m_aes192(k2, s2) ^ p2;
    key = k1; state = s1; p_c_text = p1;
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 12; k++) tick();
    n_tests++;
    if (out_valid !== 1'b1 || out !== e1) begin
      n_fail++;
      $display("FAIL b2b_first: valid=%b out=%h want 1 %h", out_valid, out, e1);
    end
    key = k2; state = s2; p_c_text = p2; start = 1'b1;
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_launch: valid=%b want 0", out_valid);
    end
    for (int k = 1; k <= 12; k++) tick();
    n_tests++;
    if (out_valid !== 1'b1 || out !== e2) begin
      n_fail++;
      $display("FAIL b2b_second: valid=%b out=%h want 1 %h", out_valid, out, e2);
    end
  endtask

  task automatic test_reset_mid_op();
    int good;
    key = KAT_KEY; state = KAT_ST; p_c_text = rnd128();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) tick();
    #2;
    rst_ni = 1'b0;
    start  = 1'b0;
    #1;
    n_tests++;
    if (out !== 128'h0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_op: out=%h valid=%b want 0/0", out, out_valid);
    end
    tick();
    rst_ni = 1'b1;
    good = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (out === 128'h0 && out_valid === 1'b0) good++;
    end
    n_tests++;
    if (good != 15) begin
      n_fail++;
      $display("FAIL reset_no_partial: quiet cycles=%0d want 15", good);
    end
  endtask

  task automatic test_start_at_reset();
    int lat;
    rst_ni = 1'b0;
    key = KAT_KEY; state = KAT_ST; p_c_text = '0; start = 1'b1;
    tick();
    rst_ni = 1'b1;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    n_tests++;
    if (lat != 13 || out !== KAT_CT) begin
      n_fail++;
      $display("FAIL start_at_reset: edges=%0d out=%h want 13 %h", lat, out, KAT_CT);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    init_model();
    test_reset();
    test_kat();
    test_xor_modes();
    test_random();
    test_isolation();
    test_relaunch();
    test_back_to_back();
    test_reset_mid_op();
    test_start_at_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
